// File: rtl/datagram_frame_sync_pkg.sv
// Shared types, constants and helpers for the datagram frame synchroniser.
package datagram_frame_sync_pkg;

  // Default datagram width used by the game core.
  localparam int unsigned MESSAGE_SIZE         = 8;

  // Default number of commit-less frames before the display is flagged stale.
  localparam int unsigned STALE_FRAMES_DEFAULT = 8;

  // Width of the VGA timing counters.
  localparam int unsigned VGA_CNT_W            = 10;

  // Width of the saturating drop and frame counters.
  localparam int unsigned SAT_W                = 8;

  // Handoff state between the core-facing shadow and the display register.
  typedef enum logic [1:0] {
    SYNC_EMPTY,
    SYNC_PENDING,
    SYNC_COMMIT
  } sync_state_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value);
    return (value == {SAT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/datagram_frame_sync_vblank_edge_detect.sv
// Produces a single-cycle vb_start at the first pixel of vertical blanking.
// The registered previous condition makes the pulse fire once per frame
// even if the timing controller parks on the blanking origin, and counter
// wrap-around needs no special handling.
module vblank_edge_detect
  import datagram_frame_sync_pkg::*;
#(
  parameter int unsigned VGA_YRES = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VGA_CNT_W-1:0] h_cnt,
  input  logic [VGA_CNT_W-1:0] v_cnt,
  output logic                 vb_start
);

  localparam logic [VGA_CNT_W-1:0] VB_LINE = VGA_CNT_W'(VGA_YRES);

  logic vb_cond;
  logic prev_vb;

  assign vb_cond  = (v_cnt == VB_LINE) && (h_cnt == '0);
  assign vb_start = vb_cond && !prev_vb;

  // Remember last cycle's blanking condition; resets high so that a timing
  // controller sitting at the blanking origin during reset does not look
  // like a fresh frame boundary on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_vb <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop in
      // the design samples pre-edge values, independent of block ordering.
      prev_vb <= vb_cond;
    end
  end

endmodule

// File: rtl/datagram_frame_sync.sv
// Tear-free handoff of game-state datagrams to a VGA quadrant output.
// The newest datagram from the core is held in a shadow register and copied
// to the display-facing register only at vertical blanking start, so a
// frame is always drawn from a single game state. Also reports frame ticks,
// counts overwritten updates and flags a display that has stopped updating.
module datagram_frame_sync
  import datagram_frame_sync_pkg::*;
#(
  parameter int unsigned MSG_W        = MESSAGE_SIZE,
  parameter int unsigned VGA_XRES     = 640,
  parameter int unsigned VGA_YRES     = 480,
  parameter int unsigned STALE_FRAMES = STALE_FRAMES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MSG_W-1:0]     in_datagram,
  input  logic [VGA_CNT_W-1:0] h_cnt,
  input  logic [VGA_CNT_W-1:0] v_cnt,
  output logic [MSG_W-1:0]     out_datagram,
  output logic                 out_valid,
  output logic                 commit_pulse,
  output logic                 frame_tick,
  output logic [SAT_W-1:0]     drop_cnt,
  output logic                 stale
);

  // Reject parameter sets the counters and timing inputs cannot represent.
  localparam bit PARAMS_OK = (MSG_W > 0)
                          && (VGA_XRES > 0) && (VGA_XRES < (1 << VGA_CNT_W))
                          && (VGA_YRES > 0) && (VGA_YRES < (1 << VGA_CNT_W))
                          && (STALE_FRAMES >= 1) && (STALE_FRAMES <= 255);

  if (!PARAMS_OK) begin : g_param_check
    $error("datagram_frame_sync: parameter out of supported range");
  end

  localparam logic [SAT_W-1:0] STALE_LIMIT = SAT_W'(STALE_FRAMES);

  sync_state_t      state;
  logic [MSG_W-1:0] shadow;
  logic [SAT_W-1:0] frame_cnt;
  logic [SAT_W-1:0] frame_cnt_inc;
  logic             vb_start;
  logic             accept;

  vblank_edge_detect #(
    .VGA_YRES (VGA_YRES)
  ) u_vblank_edge_detect (
    .clk      (clk),
    .rst      (rst),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .vb_start (vb_start)
  );

  assign accept        = in_valid && in_ready;
  assign frame_cnt_inc = sat_inc(frame_cnt);

  // Handoff FSM with all outputs registered: shadow capture, drop
  // accounting, commit into the display register and stale tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= SYNC_EMPTY;
      // NOTE: the shadow is cleared on reset on purpose: a reset must
      // discard pending game state rather than let it reach the display.
      shadow       <= '0;
      out_datagram <= '0;
      out_valid    <= 1'b0;
      commit_pulse <= 1'b0;
      frame_tick   <= 1'b0;
      drop_cnt     <= '0;
      stale        <= 1'b0;
      frame_cnt    <= '0;
      in_ready     <= 1'b0;
    end else begin
      commit_pulse <= 1'b0;
      frame_tick   <= vb_start;

      unique case (state)
        SYNC_EMPTY: begin
          in_ready <= 1'b1;
          if (accept) begin
            shadow <= in_datagram;
            state  <= SYNC_PENDING;
          end
          // Nothing was pending when blanking began, so this frame shows
          // the previous state again; data accepted in this same cycle
          // waits for the next blanking interval.
          if (vb_start) begin
            frame_cnt <= frame_cnt_inc;
            stale     <= (frame_cnt_inc >= STALE_LIMIT) && out_valid;
          end
        end

        SYNC_PENDING: begin
          // A newer datagram replaces the pending one; the older one is
          // lost and counted, including when it arrives with vb_start.
          if (accept) begin
            shadow   <= in_datagram;
            drop_cnt <= sat_inc(drop_cnt);
          end
          if (vb_start) begin
            state    <= SYNC_COMMIT;
            in_ready <= 1'b0;
          end else begin
            in_ready <= 1'b1;
          end
        end

        SYNC_COMMIT: begin
          out_datagram <= shadow;
          out_valid    <= 1'b1;
          commit_pulse <= 1'b1;
          frame_cnt    <= '0;
          stale        <= 1'b0;
          in_ready     <= 1'b1;
          state        <= SYNC_EMPTY;
        end

        default: begin
          in_ready <= 1'b0;
          state    <= SYNC_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datagram_frame_sync.sv
// Self-checking bench for datagram_frame_sync. Expected commits are queued
// when the stimulus makes them due and popped by a monitor when the DUT
// raises commit_pulse; cycle-level behaviour is checked against constants.
module tb_datagram_frame_sync;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_datagram;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [7:0] out_datagram;
  logic       out_valid;
  logic       commit_pulse;
  logic       frame_tick;
  logic [7:0] drop_cnt;
  logic       stale;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  datagram_frame_sync #(
    .MSG_W        (8),
    .VGA_XRES     (640),
    .VGA_YRES     (480),
    .STALE_FRAMES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_datagram  (in_datagram),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .out_datagram (out_datagram),
    .out_valid    (out_valid),
    .commit_pulse (commit_pulse),
    .frame_tick   (frame_tick),
    .drop_cnt     (drop_cnt),
    .stale        (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] data);
    in_valid    = 1'b1;
    in_datagram = data;
    step();
    in_valid    = 1'b0;
  endtask

  // Drive one vertical blanking start (optionally parked for several
  // cycles) and check the tick, ready and commit timing around it.
  task automatic vblank_frame(input bit exp_commit, input logic [7:0] exp_data,
                              input bit exp_stale, input int hold);
    v_cnt = 10'd480;
    h_cnt = 10'd0;
    if (exp_commit) exp_q.push_back(exp_data);
    step();
    check("frame_tick", 32'(frame_tick), 32'(1));
    check("ready_at_tick", 32'(in_ready), 32'(!exp_commit));
    check("stale_at_tick", 32'(stale), 32'(exp_stale));
    for (int i = 1; i < hold; i++) begin
      step();
      check("tick_once", 32'(frame_tick), 32'(0));
    end
    v_cnt = 10'd481;
    h_cnt = 10'd1;
    step();
    check("commit_pulse", 32'(commit_pulse), 32'(exp_commit));
    check("tick_clear", 32'(frame_tick), 32'(0));
    if (exp_commit) check("out_datagram", 32'(out_datagram), 32'(exp_data));
    v_cnt = 10'd100;
    h_cnt = 10'd5;
    step();
    check("pulse_one_cycle", 32'(commit_pulse), 32'(0));
  endtask

  // Scoreboard monitor: every commit must match the oldest expected datagram.
  always @(posedge clk) begin
    #1;
    if (rst && commit_pulse) begin
      if (exp_q.size() == 0) check("unexpected_commit", 32'(commit_pulse), 32'(0));
      else                   check("sb_data", 32'(out_datagram), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_datagram = 8'h00;
    v_cnt       = 10'd480;
    h_cnt       = 10'd0;

    // Reset values, then release while parked at the blanking origin.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_datagram", 32'(out_datagram), 32'(0));
    check("rst_drop_cnt", 32'(drop_cnt), 32'(0));
    check("rst_stale", 32'(stale), 32'(0));
    check("rst_frame_tick", 32'(frame_tick), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    check("ready_after_release", 32'(in_ready), 32'(1));
    check("no_tick_after_release", 32'(frame_tick), 32'(0));
    check("out_valid_after_release", 32'(out_valid), 32'(0));
    step();
    check("no_tick_parked", 32'(frame_tick), 32'(0));
    v_cnt = 10'd100;
    h_cnt = 10'd5;
    step();

    // Single datagram committed at the next blanking start.
    in_valid    = 1'b1;
    in_datagram = 8'hA5;
    check("ready_before_accept", 32'(in_ready), 32'(1));
    step();
    in_valid = 1'b0;
    step();
    check("no_commit_before_vblank", 32'(out_datagram), 32'(0));
    vblank_frame(1'b1, 8'hA5, 1'b0, 1);
    check("drop_after_single", 32'(drop_cnt), 32'(0));
    check("out_valid_after_commit", 32'(out_valid), 32'(1));

    // Three datagrams in one frame: newest wins, two drops.
    in_valid = 1'b1;
    in_datagram = 8'h11; step();
    in_datagram = 8'h22; step();
    in_datagram = 8'h33; step();
    in_valid = 1'b0;
    check("drop_after_three", 32'(drop_cnt), 32'(2));
    check("hold_during_frame", 32'(out_datagram), 32'(8'hA5));
    vblank_frame(1'b1, 8'h33, 1'b0, 1);
    check("drop_after_commit", 32'(drop_cnt), 32'(2));

    // Accept in the vb_start cycle while EMPTY: deferred one frame.
    v_cnt       = 10'd480;
    h_cnt       = 10'd0;
    in_valid    = 1'b1;
    in_datagram = 8'h44;
    step();
    in_valid = 1'b0;
    check("tick_empty_accept", 32'(frame_tick), 32'(1));
    check("ready_empty_accept", 32'(in_ready), 32'(1));
    v_cnt = 10'd481;
    h_cnt = 10'd1;
    step();
    check("no_commit_empty_accept", 32'(commit_pulse), 32'(0));
    check("hold_empty_accept", 32'(out_datagram), 32'(8'h33));
    v_cnt = 10'd100;
    h_cnt = 10'd5;
    step();
    vblank_frame(1'b1, 8'h44, 1'b0, 1);

    // Accept in the vb_start cycle while PENDING: newest committed, one drop.
    accept(8'h66);
    v_cnt       = 10'd480;
    h_cnt       = 10'd0;
    in_valid    = 1'b1;
    in_datagram = 8'h55;
    exp_q.push_back(8'h55);
    step();
    in_valid = 1'b0;
    check("tick_pending_accept", 32'(frame_tick), 32'(1));
    check("ready_in_commit", 32'(in_ready), 32'(0));
    check("drop_pending_accept", 32'(drop_cnt), 32'(3));
    v_cnt = 10'd481;
    h_cnt = 10'd1;
    step();
    check("commit_pending_accept", 32'(commit_pulse), 32'(1));
    check("data_pending_accept", 32'(out_datagram), 32'(8'h55));
    v_cnt = 10'd100;
    h_cnt = 10'd5;
    step();

    // Eight frames without data raise stale; frame 3 parks on the origin.
    for (int k = 1; k <= 8; k++) begin
      vblank_frame(1'b0, 8'h00, k == 8, (k == 3) ? 3 : 1);
    end
    check("hold_while_stale", 32'(out_datagram), 32'(8'h55));
    accept(8'h77);
    vblank_frame(1'b1, 8'h77, 1'b1, 1);
    check("stale_cleared", 32'(stale), 32'(0));

    // Long burst of overwrites saturates the drop counter.
    in_valid = 1'b1;
    for (int i = 0; i <= 300; i++) begin
      in_datagram = 8'(i);
      step();
    end
    in_valid = 1'b0;
    check("drop_saturated", 32'(drop_cnt), 32'(255));
    vblank_frame(1'b1, 8'h2C, 1'b0, 1);
    check("drop_saturated_after", 32'(drop_cnt), 32'(255));

    // Asynchronous reset mid-frame discards the pending datagram.
    v_cnt = 10'd200;
    h_cnt = 10'd7;
    accept(8'h99);
    #3;
    rst = 1'b0;
    #1;
    check("async_out_datagram", 32'(out_datagram), 32'(0));
    check("async_out_valid", 32'(out_valid), 32'(0));
    check("async_drop_cnt", 32'(drop_cnt), 32'(0));
    check("async_in_ready", 32'(in_ready), 32'(0));
    check("async_stale", 32'(stale), 32'(0));
    step();
    step();
    rst   = 1'b1;
    v_cnt = 10'd100;
    h_cnt = 10'd5;
    step();
    step();
    check("ready_after_rst", 32'(in_ready), 32'(1));
    vblank_frame(1'b0, 8'h00, 1'b0, 1);
    check("no_commit_after_rst", 32'(out_valid), 32'(0));
    check("data_after_rst", 32'(out_datagram), 32'(0));

    step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
